// File: rtl/irq_pkg.sv
// Shared types and constants for the four-source interrupt controller.
package irq_pkg;
    localparam int N_SRC = 4;
    localparam int ID_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    // Byte offset of a vector table entry: four bytes per source.
    function automatic logic [ID_W+1:0] vec_offset(input logic [ID_W-1:0] id);
        return {id, 2'b00};
    endfunction
endpackage

// File: rtl/irq_ctrl_rr_arb4.sv
// Combinational round-robin arbiter over four eligible requests.
module rr_arb4
    import irq_pkg::*;
(
    input  logic [N_SRC-1:0] eligible,
    input  logic [ID_W-1:0]  last,
    output logic [ID_W-1:0]  grant_id,
    output logic             any
);
    logic [ID_W-1:0] w_idx;

    // Search from the lowest priority (last itself) to the highest (last+1),
    // so the final hit is the winner.
    always_comb begin
        grant_id = '0;
        w_idx    = '0;
        for (int i = N_SRC; i >= 1; i--) begin
            w_idx = last + ID_W'(i);
            if (eligible[w_idx]) begin
                grant_id = w_idx;
            end
        end
        any = |eligible;
    end
endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge capture, pending/mask registers and the
// irq/ack/eoi handshake FSM that offers one interrupt at a time.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] VEC_BASE = 10'h3F0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_d,
    input  logic             ack,
    input  logic             eoi,
    output logic             irq,
    output logic [ID_W-1:0]  irq_id,
    output logic [PC_W-1:0]  irq_vec,
    output logic             busy,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] mask_q
);
    logic [N_SRC-1:0] r_src_q;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_mask_q;
    state_t           r_state;
    logic [ID_W-1:0]  r_irq_id;
    logic [ID_W-1:0]  r_last;
    logic             r_irq;
    logic             r_busy;

    logic [N_SRC-1:0] w_event;
    logic [N_SRC-1:0] w_eligible;
    logic [N_SRC-1:0] w_clr;
    logic [ID_W-1:0]  w_grant;
    logic             w_any;
    logic             w_ack_fire;
    state_t           w_state_next;

    assign w_event    = src & ~r_src_q;
    assign w_eligible = r_pending & r_mask_q;

    rr_arb4 u_arb (
        .eligible (w_eligible),
        .last     (r_last),
        .grant_id (w_grant),
        .any      (w_any)
    );

    always_comb begin
        w_state_next = r_state;
        w_ack_fire   = 1'b0;
        case (r_state)
            IDLE: if (w_any) w_state_next = REQ;
            REQ: begin
                if (ack) begin
                    w_state_next = SVC;
                    w_ack_fire   = 1'b1;
                end
            end
            SVC:  if (eoi) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_clr
            assign w_clr[gi] = w_ack_fire && (r_irq_id == ID_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_src_q   <= '1;
            r_pending <= '0;
            r_mask_q  <= '0;
            r_state   <= IDLE;
            r_irq_id  <= '0;
            r_last    <= ID_W'(N_SRC - 1);
            r_irq     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_src_q <= src;
            // A new edge in the ack cycle must survive the clear.
            r_pending <= (r_pending & ~w_clr) | w_event;
            if (mask_we) begin
                r_mask_q <= mask_d;
            end
            r_state <= w_state_next;
            if (r_state == IDLE && w_any) begin
                r_irq_id <= w_grant;
            end
            if (w_ack_fire) begin
                r_last <= r_irq_id;
            end
            r_irq  <= (w_state_next == REQ);
            r_busy <= (w_state_next == SVC);
        end
    end

    assign irq     = r_irq;
    assign irq_id  = r_irq_id;
    assign irq_vec = VEC_BASE + PC_W'(vec_offset(r_irq_id));
    assign busy    = r_busy;
    assign pending = r_pending;
    assign mask_q  = r_mask_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expected grant ids are queued when sources
// are pulsed and popped when the controller raises irq.
module tb_irq_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] src;
    logic       mask_we;
    logic [3:0] mask_d;
    logic       ack;
    logic       eoi;
    logic       irq;
    logic [1:0] irq_id;
    logic [9:0] irq_vec;
    logic       busy;
    logic [3:0] pending;
    logic [3:0] mask_q;

    int n_total = 0;
    int n_bad   = 0;
    int exp_q[$];

    irq_ctrl #(.PC_W(10), .VEC_BASE(10'h3F0)) dut (
        .clk     (clk),
        .reset   (reset),
        .src     (src),
        .mask_we (mask_we),
        .mask_d  (mask_d),
        .ack     (ack),
        .eoi     (eoi),
        .irq     (irq),
        .irq_id  (irq_id),
        .irq_vec (irq_vec),
        .busy    (busy),
        .pending (pending),
        .mask_q  (mask_q)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check();
        int         e;
        logic [9:0] v;
        if (exp_q.size() == 0) begin
            check_val("sb_empty", 32'(exp_q.size()), 1);
            return;
        end
        e = exp_q.pop_front();
        v = 10'h3F0 + 10'(e * 4);
        check_val("irq", 32'(irq), 1);
        check_val("irq_id", 32'(irq_id), 32'(e));
        check_val("irq_vec", 32'(irq_vec), 32'(v));
        $display("irq offered id=%0d vec=%0h (expected id=%0d vec=%0h)", irq_id, irq_vec, e, v);
    endtask

    task automatic wait_irq();
        int n = 0;
        while (irq !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (irq !== 1'b1) check_val("irq_timeout", 32'(irq), 1);
        pop_check();
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_we = 1'b1;
        mask_d  = m;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    task automatic round(input bit repulse);
        wait_irq();
        do_ack();
        check_val("svc_busy", 32'(busy), 1);
        check_val("svc_irq", 32'(irq), 0);
        if (repulse) begin
            src = 4'b0011;
            exp_q.push_back(0);
            exp_q.push_back(1);
            tick();
            src = 4'b0000;
            tick();
        end
        do_eoi();
        check_val("eoi_busy", 32'(busy), 0);
        check_val("eoi_irq", 32'(irq), 0);
    endtask

    initial begin
        reset = 1'b0; src = 4'b0001; mask_we = 1'b0; mask_d = 4'b0000;
        ack = 1'b0; eoi = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        tick();
        tick();
        check_val("rst_pending", 32'(pending), 0);
        check_val("rst_irq", 32'(irq), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_mask", 32'(mask_q), 0);
        check_val("rst_id", 32'(irq_id), 0);
        check_val("rst_vec", 32'(irq_vec), 32'h3F0);

        // Rising edge on src0 with everything enabled: two-cycle latency.
        write_mask(4'b1111);
        src = 4'b0000;
        tick();
        src = 4'b0001;
        exp_q.push_back(0);
        tick();
        check_val("lat_pending", 32'(pending), 32'b0001);
        check_val("lat_irq_early", 32'(irq), 0);
        src = 4'b0000;
        tick();
        pop_check();
        do_ack();
        check_val("t1_busy", 32'(busy), 1);
        check_val("t1_pending", 32'(pending), 0);
        do_eoi();
        check_val("t1_idle", 32'(busy), 0);

        // Masked event stays latched until the mask enables it.
        write_mask(4'b0000);
        src = 4'b0100;
        tick();
        src = 4'b0000;
        tick();
        check_val("m_pending", 32'(pending), 32'b0100);
        tick();
        check_val("m_irq", 32'(irq), 0);
        exp_q.push_back(2);
        write_mask(4'b0100);
        check_val("m_irq_delay", 32'(irq), 0);
        tick();
        pop_check();
        do_ack();
        do_eoi();

        // Fresh arbitration state, then four rounds plus re-pulses.
        reset = 1'b0;
        #2 reset = 1'b1;
        src = 4'b0000;
        write_mask(4'b1111);
        src = 4'b1111;
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        tick();
        src = 4'b0000;
        check_val("rr_pending", 32'(pending), 32'b1111);
        for (int r = 0; r < 6; r++) round(r == 1);

        // Offer is locked in REQ: mask clear and stray eoi have no effect.
        exp_q.push_back(1);
        src = 4'b0010;
        tick();
        src = 4'b0000;
        wait_irq();
        write_mask(4'b0000);
        check_val("lock_irq", 32'(irq), 1);
        check_val("lock_id", 32'(irq_id), 1);
        do_eoi();
        check_val("eoi_ign_irq", 32'(irq), 1);
        check_val("eoi_ign_busy", 32'(busy), 0);
        do_ack();
        check_val("lock_busy", 32'(busy), 1);
        check_val("lock_pending", 32'(pending), 0);
        do_eoi();

        // Event in the same cycle as its own ack: set wins, re-offered.
        write_mask(4'b1111);
        exp_q.push_back(1);
        src = 4'b0010;
        tick();
        src = 4'b0000;
        wait_irq();
        ack = 1'b1;
        src = 4'b0010;
        exp_q.push_back(1);
        tick();
        ack = 1'b0;
        src = 4'b0000;
        check_val("same_pending1", 32'(pending[1]), 1);
        check_val("same_busy", 32'(busy), 1);
        do_eoi();
        check_val("same_idle", 32'(busy), 0);
        wait_irq();

        // Async reset in SVC with a source held high across release.
        do_ack();
        check_val("pre_rst_busy", 32'(busy), 1);
        src = 4'b1000;
        tick();
        check_val("pre_rst_pending", 32'(pending), 32'b1000);
        #2 reset = 1'b0;
        #1;
        check_val("arst_busy", 32'(busy), 0);
        check_val("arst_irq", 32'(irq), 0);
        check_val("arst_pending", 32'(pending), 0);
        check_val("arst_mask", 32'(mask_q), 0);
        reset = 1'b1;
        tick();
        write_mask(4'b1111);
        repeat (3) tick();
        check_val("post_rst_irq", 32'(irq), 0);
        check_val("post_rst_pending", 32'(pending), 0);
        check_val("sb_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Four-source interrupt controller that sequences interrupt entry and exit for the single-cycle CPU core. It sits beside the `uc` control unit and drives the existing `ie1..ie4` enable path. It latches rising edges on four request lines and arbitrates them round-robin under a software-written enable mask. It then offers one interrupt at a time to the core with an irq/ack/eoi handshake, so the core can vector its PC and later return.

## Interface
Parameters:
- `PC_W`, 10, width of the CPU program counter and of `irq_vec`.
- `VEC_BASE`, 10'h3F0, base address of the vector table; vector for id n is `VEC_BASE + 4*n`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `src`  in  4  raw interrupt request lines; synchronous to `clk`; event is a 0→1 transition.
- `mask_we`  in  1  write strobe for the enable mask.
- `mask_d`  in  4  new enable mask; bit n = 1 enables source n.
- `ack`  in  1  core has accepted the offered interrupt (return address saved, PC loaded).
- `eoi`  in  1  core executed return-from-interrupt.
- `irq`  out  1  interrupt offered to the core.
- `irq_id`  out  2  id of the offered or in-service source.
- `irq_vec`  out  PC_W  `VEC_BASE + {irq_id,2'b00}`, computed modulo 2^PC_W.
- `busy`  out  1  an interrupt is in service.
- `pending`  out  4  latched, not yet acknowledged events.
- `mask_q`  out  4  current enable mask.

## Operation
- Edge detect: `src_q` register. Event vector is `src & ~src_q`. `src_q` resets to 4'b1111, so a line already high at reset release is not an event.
- Pending: `pending[n]` is set on an event for n. It is cleared only by `ack` while id n is offered. An event on n in the same cycle as its ack clear leaves the bit set (set wins).
- Masked pending bits stay latched and are not eligible. They become eligible the cycle after the mask enables them.
- Eligible = `pending & mask_q`.
- Arbitration: round-robin over eligible bits, starting at `last+1` mod 4. `last` resets to 3, so id 0 has first priority after reset. It lives in sub-module `rr_arb4` (combinational).
- FSM states:
  - IDLE: `irq`=0, `busy`=0. If eligible ≠ 0, latch the winner into `irq_id` and go to REQ.
  - REQ: `irq`=1. `irq_id` is locked; mask changes and new events do not withdraw or change it. On `ack`, clear `pending[irq_id]`, set `last` = `irq_id`, go to SVC.
  - SVC: `irq`=0, `busy`=1, `irq_id` held. On `eoi`, go to IDLE.
- No nesting. `ack` outside REQ and `eoi` outside SVC are ignored.
- `mask_we` is accepted in any state; `mask_q` updates on that edge.
- Reset (async, any state, mid-handshake included) forces:
  - state IDLE
  - `irq`=0, `busy`=0, `irq_id`=0
  - `irq_vec`=`VEC_BASE`
  - `pending`=0, `mask_q`=0 (all disabled)
  - `last`=3, `src_q`=4'b1111

## Timing
- `src[n]` rises before edge k: `pending[n]`=1 after edge k. If enabled and IDLE, `irq`=1 after edge k+1. Latency is 2 cycles.
- `ack` sampled high at edge a: `irq`=0, `busy`=1 after edge a.
- `eoi` at edge e: `busy`=0 after edge e. If another source is eligible, `irq`=1 after edge e+1.
- `irq_vec` is a combinational function of registered `irq_id`, with no added latency.
- All outputs are registered except `irq_vec`.
- `ack` and `eoi` are single-cycle pulses from `uc`. A held `ack` has effect only in REQ; a held `eoi` only in SVC.

## Structure
- Package `irq_pkg` holds:
  - `N_SRC`=4 and `ID_W`=2
  - state typedef {IDLE, REQ, SVC}
  - vector-offset function `id*4`
- Sub-module `rr_arb4` takes eligible[3:0] and last[1:0], and returns grant_id[1:0] and any.
- Top `irq_ctrl` holds the edge detect, pending/mask registers and FSM, and instantiates `rr_arb4`.

## Test plan
- Reset with `src`=4'b0001 held: no pending. Drop `src` then raise it, with mask 4'b1111 → `irq`=1, `irq_id`=0, `irq_vec`=10'h3F0 two cycles after the rise.
- Mask 4'b0000 and pulse `src[2]`: `pending`=4'b0100, `irq`=0. Write mask 4'b0100 → `irq`=1, `irq_id`=2, `irq_vec`=10'h3F8.
- All four sources pending, mask 4'b1111: four full ack/eoi rounds grant ids 0,1,2,3. Re-pulsing src0 and src1 during service of 1 yields the next grants 2,3,0.
- In REQ with `irq_id`=1, clear the mask to 0: `irq` stays 1 and `irq_id` stays 1 until `ack`. Assert `eoi` in REQ: ignored.
- New `src[1]` edge in the same cycle as `ack` for id 1: after the edge, `pending[1]`=1 and `busy`=1. After `eoi`, id 1 is re-offered.
- Assert `reset` low asynchronously during SVC: `busy`, `irq`, `pending` and `mask_q` go to 0 immediately. After release, no `irq` without a new edge.
